// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter that shares one combinational multiplier between N_REQ requesters.
// Each requester has a valid/ready operand channel and a valid/ready result channel.
// Only one operation is in flight at a time: IDLE -> CALC -> RESP -> IDLE.
// Optional build macro MUL_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead
// of round-robin; latency and handshakes are the same in both builds.
module mul_share_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MUL_LAT = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [N_REQ-1:0]         i_req_valid,
  output logic [N_REQ-1:0]         o_req_ready,
  input  logic [N_REQ*WIDTH-1:0]   i_req_a,
  input  logic [N_REQ*WIDTH-1:0]   i_req_b,
  output logic [WIDTH-1:0]         o_mul_a,
  output logic [WIDTH-1:0]         o_mul_b,
  input  logic [2*WIDTH-1:0]       i_mul_p,
  output logic [N_REQ-1:0]         o_rsp_valid,
  input  logic [N_REQ-1:0]         i_rsp_ready,
  output logic [2*WIDTH-1:0]       o_rsp_data,
  output logic                     o_busy
);

  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CntW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  typedef enum logic [1:0] {StIdle, StCalc, StResp} state_e;

  state_e               r_state;
  state_e               w_state_next;
  logic [WIDTH-1:0]     r_op_a;
  logic [WIDTH-1:0]     r_op_b;
  logic [2*WIDTH-1:0]   r_rsp_data;
  logic [N_REQ-1:0]     r_rsp_valid;
  logic [IdxW-1:0]      r_grant_idx;
  logic [IdxW-1:0]      r_last_grant;
  logic [CntW-1:0]      r_cnt;
  logic [IdxW-1:0]      w_grant;
  logic                 w_any;

  // Grant selection; loop runs from lowest to highest priority so the last hit wins.
  always_comb begin
    w_grant = '0;
    w_any   = |i_req_valid;
`ifdef MUL_ARB_FIXED_PRIO_EN
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (i_req_valid[i]) w_grant = IdxW'(i);
    end
`else
    for (int k = N_REQ; k >= 1; k--) begin
      if (i_req_valid[(int'(r_last_grant) + k) % int'(N_REQ)]) begin
        w_grant = IdxW'((int'(r_last_grant) + k) % int'(N_REQ));
      end
    end
`endif
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (w_any) w_state_next = StCalc;
      StCalc: if (r_cnt == '0) w_state_next = StResp;
      StResp: if (i_rsp_ready[r_grant_idx]) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Operand capture, latency counter, result register and grant history.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_rsp_data   <= '0;
      r_rsp_valid  <= '0;
      r_grant_idx  <= '0;
      r_last_grant <= IdxW'(N_REQ - 1);
      r_cnt        <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_any) begin
            r_op_a      <= i_req_a[w_grant*WIDTH +: WIDTH];
            r_op_b      <= i_req_b[w_grant*WIDTH +: WIDTH];
            r_grant_idx <= w_grant;
            r_cnt       <= CntW'(MUL_LAT - 1);
          end
        end
        StCalc: begin
          if (r_cnt == '0) begin
            r_rsp_data               <= i_mul_p;
            r_rsp_valid              <= '0;
            r_rsp_valid[r_grant_idx] <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        StResp: begin
          // Only the owning requester's ready completes the transfer.
          if (i_rsp_ready[r_grant_idx]) begin
            r_rsp_valid  <= '0;
            r_last_grant <= r_grant_idx;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs; req_ready is gated by reset so it reads zero while reset is held.
  always_comb begin
    o_req_ready = '0;
    if ((r_state == StIdle) && w_any && i_rst_n) o_req_ready[w_grant] = 1'b1;
    o_busy      = (r_state != StIdle);
    o_mul_a     = r_op_a;
    o_mul_b     = r_op_b;
    o_rsp_valid = r_rsp_valid;
    o_rsp_data  = r_rsp_data;
  end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Scoreboard bench for mul_share_arbiter with a transaction-level arbitration model.
module tb_mul_share_arbiter;
  localparam int N_REQ   = 4;
  localparam int WIDTH   = 8;
  localparam int MUL_LAT = 3;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic [WIDTH-1:0]       mul_a;
  logic [WIDTH-1:0]       mul_b;
  logic [2*WIDTH-1:0]     mul_p;
  logic [N_REQ-1:0]       rsp_valid;
  logic [N_REQ-1:0]       rsp_ready;
  logic [2*WIDTH-1:0]     rsp_data;
  logic                   busy;

  logic [WIDTH-1:0] op_a [N_REQ];
  logic [WIDTH-1:0] op_b [N_REQ];
  int               remain [N_REQ];

  typedef struct {
    int                 idx;
    logic [2*WIDTH-1:0] p;
    int                 t;
  } exp_t;
  exp_t sb [$];

  int               n_checks = 0;
  int               n_errors = 0;
  int               cyc = 0;
  int               m_last = N_REQ - 1;
  int               m_out = 0;
  logic [N_REQ-1:0] hs_vec = '0;

  mul_share_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_a     (req_a),
    .i_req_b     (req_b),
    .o_mul_a     (mul_a),
    .o_mul_b     (mul_b),
    .i_mul_p     (mul_p),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_data  (rsp_data),
    .o_busy      (busy)
  );

  // Stand-in for the shared combinational multiplier.
  assign mul_p = (2*WIDTH)'(mul_a) * (2*WIDTH)'(mul_b);

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      req_a[i*WIDTH +: WIDTH] = op_a[i];
      req_b[i*WIDTH +: WIDTH] = op_b[i];
    end
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [N_REQ-1:0] onehot(input int idx);
    logic [N_REQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Who should win among the valid requesters, given the previous winner.
  function automatic int pick(input logic [N_REQ-1:0] v, input int last);
`ifdef MUL_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N_REQ; i++) if (v[i]) return i;
`else
    for (int k = 1; k <= N_REQ; k++) if (v[(last + k) % N_REQ]) return (last + k) % N_REQ;
`endif
    return -1;
  endfunction

  // Request side: predicts grants, checks req_ready/busy, pushes expected results.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      m_last = N_REQ - 1;
      m_out  = 0;
      hs_vec = '0;
    end else begin
      logic [N_REQ-1:0] exp_rdy;
      int               g;
      exp_rdy = '0;
      g       = -1;
      if (m_out == 0) g = pick(req_valid, m_last);
      if (g >= 0) exp_rdy[g] = 1'b1;
      check("req_ready", 32'(req_ready), 32'(exp_rdy));
      check("busy", 32'(busy), 32'(m_out != 0));
      hs_vec = exp_rdy;
      if (m_out != 0 && (rsp_valid & rsp_ready) != '0) m_out = 0;
      if (g >= 0) begin
        sb.push_back('{g, (2*WIDTH)'(op_a[g]) * (2*WIDTH)'(op_b[g]), cyc});
        m_out  = 1;
        m_last = g;
      end
    end
  end

  // Response monitor: checks timing, owner and data of every result.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sb.size() == 0) begin
        check("rsp_valid_idle", 32'(rsp_valid), 32'd0);
      end else if (cyc < sb[0].t + MUL_LAT + 1) begin
        check("rsp_valid_early", 32'(rsp_valid), 32'd0);
      end else begin
        check("rsp_valid", 32'(rsp_valid), 32'(onehot(sb[0].idx)));
        check("rsp_data", 32'(rsp_data), 32'(sb[0].p));
        if (rsp_ready[sb[0].idx]) void'(sb.pop_front());
      end
    end
  end

  task automatic issue(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_valid[i] = 1'b1;
    op_a[i]      = a;
    op_b[i]      = b;
  endtask

  task automatic step(input bit rnd);
    @(posedge clk);
    #1;
    for (int i = 0; i < N_REQ; i++) begin
      if (hs_vec[i]) begin
        if (remain[i] > 0) begin
          remain[i]--;
          op_a[i] = WIDTH'($urandom);
          op_b[i] = WIDTH'($urandom);
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
    if (rnd) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(0, 2) == 0) issue(i, WIDTH'($urandom), WIDTH'($urandom));
        end else if ($urandom_range(0, 7) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = N_REQ'($urandom);
    end
  endtask

  task automatic run(input int n);
    repeat (n) step(1'b0);
  endtask

  task automatic wait_rsp(input int i, input int budget);
    int n;
    n = 0;
    while (!rsp_valid[i] && n < budget) begin
      step(1'b0);
      n++;
    end
    check("wait_rsp", 32'(rsp_valid[i]), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = '1;
    for (int i = 0; i < N_REQ; i++) begin
      op_a[i]   = '0;
      op_b[i]   = '0;
      remain[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_mul_a", 32'(mul_a), 32'd0);
    check("rst_mul_b", 32'(mul_b), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    req_valid[3] = 1'b1;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    rst_n     = 1'b1;

    // Single request.
    issue(2, 8'd7, 8'd9);
    wait_rsp(2, 20);
    check("single_data", 32'(rsp_data), 32'h003F);
    run(3);

    // All requesters at once; requester 0 asks twice so the wrap is exercised.
    for (int i = 0; i < N_REQ; i++) issue(i, WIDTH'(i + 1), 8'd10);
    remain[0] = 1;
    run(40);

    // Backpressure on requester 1 while requester 0 competes.
    rsp_ready = '0;
    issue(1, 8'hFF, 8'hFF);
    issue(0, 8'd3, 8'd4);
    wait_rsp(1, 20);
    repeat (5) begin
      step(1'b0);
      check("bp_valid", 32'(rsp_valid), 32'h2);
      check("bp_data", 32'(rsp_data), 32'hFE01);
      check("bp_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = '1;
    run(20);

    // Ready on the wrong port must not complete.
    rsp_ready = 4'b0001;
    issue(3, 8'd12, 8'd13);
    wait_rsp(3, 20);
    repeat (4) begin
      step(1'b0);
      check("wrong_port_valid", 32'(rsp_valid), 32'h8);
    end
    rsp_ready = '1;
    run(10);

    // Reset during CALC.
    issue(1, 8'd5, 8'd6);
    step(1'b0);
    step(1'b0);
    issue(0, 8'd2, 8'd3);
    issue(3, 8'd4, 8'd5);
    @(posedge clk);
    #3;
    check("mid_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rsp_data", 32'(rsp_data), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_mul_a", 32'(mul_a), 32'd0);
    check("mid_req_ready", 32'(req_ready), 32'd0);
    step(1'b0);
    step(1'b0);
    rst_n = 1'b1;
    #1;
    check("post_rst_grant", 32'(req_ready), 32'h1);
    run(30);

    // Edge operands.
    issue(0, 8'h00, 8'hAB);
    issue(1, 8'h01, 8'hFF);
    issue(2, 8'hFF, 8'hFF);
    run(40);

    // Randomized traffic with random drops and backpressure.
    repeat (1500) step(1'b1);
    req_valid = '0;
    rsp_ready = '1;
    run(20);
    check("drain_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
